// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store front end between a core and a cache with a
// separate hit-check port, registered read-return port and write port.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        flush,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [15:0] miss_cycles,
    output logic [31:0] c_hit_check,
    input  logic        c_hit_check_result,
    output logic        c_rden,
    output logic [31:0] c_riaddr,
    input  logic [31:0] c_roaddr,
    input  logic        c_rvalid,
    input  logic [31:0] c_rdata,
    output logic        c_wren,
    output logic [31:0] c_waddr,
    output logic [31:0] c_wdata,
    output logic        c_stall,
    output logic [2:0]  fsm_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, so at most one request is ever in flight.

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        RESP  = 3'd2,
        WRITE = 3'd3,
        ERR   = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_next;
    logic          load_resp_q;
    logic [31:0]   load_data_q;

    logic accept;
    logic hit_go;
    logic miss_step;
    logic timed_out;
    logic rd_match;

    assign accept    = req_valid && (state == IDLE);
    assign hit_go    = (state == CHECK) && !flush && c_hit_check_result;
    assign miss_step = (state == CHECK) && !flush && !c_hit_check_result;
    assign wait_next = wait_cnt + 1'b1;
    assign timed_out = miss_step && (wait_next == CW'(TIMEOUT_CYCLES));
    assign rd_match  = (state == RESP) && c_rvalid && (c_roaddr == addr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (req_addr[1:0] != 2'b00) ? ERR : CHECK;
                end
            end
            CHECK: begin
                // Flush outranks a same-cycle hit so an aborted store never writes.
                if (flush) begin
                    state_next = IDLE;
                end else if (hit_go) begin
                    state_next = we_q ? WRITE : RESP;
                end else if (timed_out) begin
                    state_next = ERR;
                end
            end
            RESP: begin
                if (rd_match) begin
                    state_next = IDLE;
                end
            end
            WRITE:   state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        c_rden     = (state == CHECK);
        c_wren     = (state == WRITE);
        resp_err   = (state == ERR);
        resp_valid = (state == WRITE) || (state == ERR) || load_resp_q;
        resp_data  = load_resp_q ? load_data_q : 32'h0;
        c_stall    = 1'b0;
        fsm_state  = state;
    end

    // Cache-side addresses come straight from the request latch, so they
    // cannot change while a request is in CHECK.
    assign c_hit_check = addr_q;
    assign c_riaddr    = addr_q;
    assign c_waddr     = addr_q;
    assign c_wdata     = wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            wait_cnt    <= '0;
            miss_cycles <= 16'h0;
            load_resp_q <= 1'b0;
            load_data_q <= 32'h0;
        end else begin
            if (accept) begin
                we_q     <= req_we;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                wait_cnt <= '0;
            end
            if (miss_step) begin
                wait_cnt <= wait_next;
                if (miss_cycles != 16'hffff) begin
                    miss_cycles <= miss_cycles + 16'h1;
                end
            end
            // Load data is registered, giving the response one cycle after the read return.
            load_resp_q <= rd_match;
            if (rd_match) begin
                load_data_q <= c_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a cache responder model, request driver task and
// a response/write scoreboard; a second instance runs with a short timeout.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        flush = 1'b0;
    logic [31:0] c_roaddr = 32'h0;
    logic        c_rvalid = 1'b0;
    logic [31:0] c_rdata = 32'h0;
    logic        hit;
    logic        sel = 1'b0;

    logic        a_req_ready, a_resp_valid, a_resp_err, a_c_rden, a_c_wren, a_c_stall;
    logic [31:0] a_resp_data, a_c_hit_check, a_c_riaddr, a_c_waddr, a_c_wdata;
    logic [15:0] a_miss_cycles;
    logic [2:0]  a_fsm_state;
    logic        b_req_ready, b_resp_valid, b_resp_err, b_c_rden, b_c_wren, b_c_stall;
    logic [31:0] b_resp_data, b_c_hit_check, b_c_riaddr, b_c_waddr, b_c_wdata;
    logic [15:0] b_miss_cycles;
    logic [2:0]  b_fsm_state;

    logic        m_req_ready, m_resp_valid, m_resp_err, m_c_rden, m_c_wren, m_c_stall;
    logic [31:0] m_resp_data, m_c_hit_check, m_c_riaddr, m_c_waddr, m_c_wdata;
    logic [15:0] m_miss_cycles;

    assign m_req_ready   = sel ? b_req_ready   : a_req_ready;
    assign m_resp_valid  = sel ? b_resp_valid  : a_resp_valid;
    assign m_resp_err    = sel ? b_resp_err    : a_resp_err;
    assign m_resp_data   = sel ? b_resp_data   : a_resp_data;
    assign m_c_rden      = sel ? b_c_rden      : a_c_rden;
    assign m_c_wren      = sel ? b_c_wren      : a_c_wren;
    assign m_c_stall     = sel ? b_c_stall     : a_c_stall;
    assign m_c_hit_check = sel ? b_c_hit_check : a_c_hit_check;
    assign m_c_riaddr    = sel ? b_c_riaddr    : a_c_riaddr;
    assign m_c_waddr     = sel ? b_c_waddr     : a_c_waddr;
    assign m_c_wdata     = sel ? b_c_wdata     : a_c_wdata;
    assign m_miss_cycles = sel ? b_miss_cycles : a_miss_cycles;

    mem_access_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
        .resp_valid(a_resp_valid), .resp_data(a_resp_data), .resp_err(a_resp_err),
        .miss_cycles(a_miss_cycles), .c_hit_check(a_c_hit_check),
        .c_hit_check_result(hit), .c_rden(a_c_rden), .c_riaddr(a_c_riaddr),
        .c_roaddr(c_roaddr), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .c_wren(a_c_wren), .c_waddr(a_c_waddr), .c_wdata(a_c_wdata),
        .c_stall(a_c_stall), .fsm_state(a_fsm_state)
    );

    mem_access_ctrl #(.TIMEOUT_CYCLES(8)) dut_to (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
        .resp_valid(b_resp_valid), .resp_data(b_resp_data), .resp_err(b_resp_err),
        .miss_cycles(b_miss_cycles), .c_hit_check(b_c_hit_check),
        .c_hit_check_result(hit), .c_rden(b_c_rden), .c_riaddr(b_c_riaddr),
        .c_roaddr(c_roaddr), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .c_wren(b_c_wren), .c_waddr(b_c_waddr), .c_wdata(b_c_wdata),
        .c_stall(b_c_stall), .fsm_state(b_fsm_state)
    );

    // clock
    always #5 clk = ~clk;

    // cache model: misses miss_target times per request, then hits; read data returns one cycle later
    int          miss_seen = 0;
    int          miss_target = 0;
    logic        force_miss = 1'b0;
    logic [31:0] cache_data = 32'h0;

    assign hit = !force_miss && (miss_seen >= miss_target);

    always @(posedge clk) begin
        c_rvalid <= m_c_rden && hit;
        c_roaddr <= m_c_riaddr;
        c_rdata  <= cache_data;
        if (req_valid && m_req_ready) miss_seen <= 0;
        else if (m_c_rden && !hit)    miss_seen <= miss_seen + 1;
    end

    // scoreboard
    int          n_tests = 0;
    int          n_fail = 0;
    int          exp_miss = 0;
    logic [32:0] exp_q[$];
    logic [63:0] wexp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && m_resp_valid) begin
            if (exp_q.size() == 0) check("unexp_resp", 1, 0);
            else check("resp", {m_resp_err, m_resp_data}, exp_q.pop_front());
        end
        if (!rst && m_c_wren) begin
            if (wexp_q.size() == 0) check("unexp_wren", 1, 0);
            else check("wren", {m_c_waddr, m_c_wdata}, wexp_q.pop_front());
        end
    end

    // drivers
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b0;
        flush = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_miss = 0;
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_we = we;
        req_addr = addr;
        req_wdata = wdata;
        @(posedge clk);
    endtask

    task automatic run_req(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input int misses,
                           input logic [31:0] rdata, input logic to_err);
        int   lat, rden_n, wren_n, exp_lat, exp_rden;
        logic mis, err;
        bit   done;
        mis = (addr[1:0] != 2'b00);
        err = mis || to_err;
        exp_lat  = mis ? 1 : to_err ? misses + 1 : we ? misses + 2 : misses + 3;
        exp_rden = mis ? 0 : to_err ? misses : misses + 1;
        exp_q.push_back({err, err || we ? 32'h0 : rdata});
        if (!err && we) wexp_q.push_back({addr, wdata});
        if (!mis) exp_miss += misses;
        @(negedge clk);
        check({tag, "_ready"}, m_req_ready, 1);
        miss_target = misses;
        cache_data = rdata;
        issue(we, addr, wdata);
        lat = 0; rden_n = 0; wren_n = 0; done = 0;
        while (!done && lat < 300) begin
            @(negedge clk);
            req_valid = 1'b0;
            lat++;
            rden_n += int'(m_c_rden);
            wren_n += int'(m_c_wren);
            if (m_resp_valid) done = 1;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_rden"}, rden_n, exp_rden);
        check({tag, "_wren"}, wren_n, (!err && we) ? 1 : 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, m_req_ready, 1);
        check({tag, "_rvalid"}, {m_resp_valid, m_resp_err, m_c_rden, m_c_wren, m_c_stall}, 0);
        check({tag, "_rdata"}, m_resp_data, 0);
        check({tag, "_hitchk"}, m_c_hit_check, 0);
        check({tag, "_riaddr"}, m_c_riaddr, 0);
        check({tag, "_waddr"}, m_c_waddr, 0);
        check({tag, "_wdata"}, m_c_wdata, 0);
        check({tag, "_miss"}, m_miss_cycles, 0);
    endtask

    initial begin
        logic        we;
        logic [31:0] addr;

        do_reset();
        check_reset_outputs("rst");

        run_req("load_hit", 1'b0, 32'h0000_1004, 32'h0, 0, 32'hDEADBEEF, 1'b0);
        run_req("store_miss", 1'b1, 32'h0000_2008, 32'h12345678, 10, 32'h0, 1'b0);
        check("store_miss_cnt", m_miss_cycles, 10);
        run_req("misalign", 1'b0, 32'h0000_1002, 32'h0, 0, 32'h5555_AAAA, 1'b0);

        for (int i = 0; i < 12; i++) begin
            we = 1'($urandom_range(0, 1));
            addr = $urandom;
            if ($urandom_range(0, 4) != 0) addr[1:0] = 2'b00;
            run_req("rand", we, addr, $urandom, $urandom_range(0, 5), $urandom, 1'b0);
        end
        check("miss_total", m_miss_cycles, 16'(exp_miss));

        // flush in the same cycle as the hit
        @(negedge clk);
        miss_target = 3;
        issue(1'b1, 32'h0000_3000, 32'hCAFE_F00D);
        repeat (3) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        @(negedge clk);
        check("flush_hit_seen", {hit, m_c_rden}, 2'b11);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle", m_req_ready, 1);
        check("flush_noresp", {m_resp_valid, m_c_wren}, 0);
        repeat (4) @(negedge clk);
        check("flush_miss", m_miss_cycles, 16'(exp_miss + 3));

        // reset while waiting in CHECK
        force_miss = 1'b1;
        issue(1'b0, 32'h0000_4000, 32'h0);
        repeat (3) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        rst = 1'b0;
        force_miss = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_mid_quiet", m_req_ready, 1);

        // timeout on the short-timeout instance
        sel = 1'b1;
        force_miss = 1'b1;
        do_reset();
        run_req("timeout", 1'b0, 32'h0000_5000, 32'h0, 8, 32'h1111_2222, 1'b1);
        @(negedge clk);
        check("timeout_ready", m_req_ready, 1);
        check("timeout_miss", m_miss_cycles, 8);
        force_miss = 1'b0;

        repeat (3) @(negedge clk);
        check("resp_q_empty", exp_q.size(), 0);
        check("wr_q_empty", wexp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of CLK.
REQ-002 Parameter: TIMEOUT_CYCLES, default 4096, maximum consecutive miss cycles before an error response.
REQ-003 CLK  in  1  clock.
REQ-004 RST  in  1  synchronous active-high reset.
REQ-005 REQ_VALID  in  1  core request valid.
REQ-006 REQ_READY  out  1  block accepts a request this cycle.
REQ-007 REQ_WE  in  1  request type: 1 = store, 0 = load.
REQ-008 REQ_ADDR  in  32  byte address.
REQ-009 REQ_WDATA  in  32  store data.
REQ-010 FLUSH  in  1  abort a request that has not yet hit.
REQ-011 RESP_VALID  out  1  one-cycle response pulse.
REQ-012 RESP_DATA  out  32  load data; 0 for stores and errors.
REQ-013 RESP_ERR  out  1  response is an error (misaligned address or timeout).
REQ-014 MISS_CYCLES  out  16  saturating count of all cycles spent waiting in CHECK on a miss.
REQ-015 C_HIT_CHECK  out  32  address driven to the cache hit-check port.
REQ-016 C_HIT_CHECK_RESULT  in  1  cache hit indication.
REQ-017 C_RDEN, C_RIADDR  out  1/32  cache read enable and address.
REQ-018 C_ROADDR, C_RVALID, C_RDATA  in  32/1/32  cache registered read address, valid and data.
REQ-019 C_WREN, C_WADDR, C_WDATA  out  1/32/32  cache write enable, address and data.
REQ-020 C_STALL  out  1  cache stall; SHALL be tied to 0.

Function
REQ-021 The block SHALL implement states IDLE, CHECK, RESP, WRITE and ERR.
REQ-022 REQ_READY SHALL be 1 only in IDLE; a request SHALL be accepted when REQ_VALID && REQ_READY, latching REQ_WE, REQ_ADDR and REQ_WDATA.
REQ-023 On accept with REQ_ADDR[1:0] != 0, the next state SHALL be ERR; otherwise it SHALL be CHECK.
REQ-024 In CHECK, outputs SHALL be C_RDEN = 1 and C_RIADDR = C_HIT_CHECK = latched address, and the cache-side signals SHALL hold stable until the state is left.
REQ-025 In all states other than CHECK, C_RDEN SHALL be 0.
REQ-026 In CHECK, when C_HIT_CHECK_RESULT = 1, the next state SHALL be RESP for a load and WRITE for a store.
REQ-027 In CHECK on a miss, the block SHALL stay in CHECK, increment a per-request wait counter, and increment MISS_CYCLES, saturating at 16'hffff.
REQ-028 If the wait counter reaches TIMEOUT_CYCLES, the next state SHALL be ERR.
REQ-029 The wait counter SHALL clear on every accept.
REQ-030 In CHECK, FLUSH = 1 SHALL return the block to IDLE with no response and no cache write; FLUSH SHALL be ignored in all other states.
REQ-031 If FLUSH and a hit occur in the same cycle, FLUSH SHALL win.
REQ-032 In RESP, the block SHALL wait for C_RVALID && C_ROADDR == latched address.
REQ-033 When that condition holds, the block SHALL pulse RESP_VALID for one cycle with RESP_DATA = C_RDATA and RESP_ERR = 0, then return to IDLE.
REQ-034 The load latency from accept to RESP_VALID SHALL be 3 cycles on an immediate hit.
REQ-035 In WRITE, the block SHALL assert C_WREN for exactly one cycle with C_WADDR = latched address and C_WDATA = latched data.
REQ-036 In that same WRITE cycle, the block SHALL pulse RESP_VALID with RESP_DATA = 0 and RESP_ERR = 0, then return to IDLE.
REQ-037 A store SHALL never assert C_WREN before the cache has reported a hit for its page.
REQ-038 In ERR, the block SHALL pulse RESP_VALID and RESP_ERR for one cycle with RESP_DATA = 0, then return to IDLE; there SHALL be no cache access in ERR.
REQ-039 RESP_VALID, RESP_ERR and C_WREN SHALL be 0 in every cycle not specified above.
REQ-040 Requests SHALL be strictly in order, with at most one request outstanding.

Reset
REQ-041 On RST, the state SHALL be IDLE.
REQ-042 On RST, REQ_READY SHALL be 1, and RESP_VALID, RESP_ERR, C_RDEN, C_WREN and C_STALL SHALL be 0.
REQ-043 On RST, RESP_DATA, C_HIT_CHECK, C_RIADDR, C_WADDR, C_WDATA, MISS_CYCLES and the latched request SHALL be 0.
REQ-044 RST asserted mid-operation SHALL abandon the request with no response and no write.

Verification
REQ-045 Load hit: load to 0x0000_1004, HIT_CHECK_RESULT = 1 immediately, cache returns 0xDEADBEEF -> RESP_VALID 3 cycles after accept with RESP_DATA = 0xDEADBEEF and RESP_ERR = 0.
REQ-046 Store after miss: store 0x12345678 to 0x0000_2008, 10 miss cycles then hit -> C_WREN pulses once with address 0x0000_2008 and data 0x12345678, MISS_CYCLES = 10, and no C_WREN during the miss cycles.
REQ-047 Misaligned request: load to 0x0000_1002 -> RESP_VALID and RESP_ERR on the cycle after accept, and C_RDEN never asserted.
REQ-048 Timeout: TIMEOUT_CYCLES = 8 with a permanent miss -> RESP_ERR pulse after 8 CHECK cycles, then REQ_READY = 1.
REQ-049 Flush on hit: FLUSH asserted in the same cycle as the hit -> no response, no write, IDLE next cycle.
REQ-050 Reset mid-CHECK: RST asserted during CHECK -> all outputs at their reset values on the next cycle, and MISS_CYCLES = 0.
